// File: rtl/game_session_ctrl.sv
// game_session_ctrl
// Session sequencer for the whack-a-mole game. Owns the pre-game countdown
// and play-time counters, a pause state, the high-score register and the
// difficulty latch. Sits between the debounced buttons / score counter and
// the mole controller and display driver.
//
// Ports:
//   clk, rst_n                  system clock, async active-low reset
//   tick_1hz                    one-clk pulse per second
//   btn_start, btn_pause,
//   btn_reset_score             debounced levels, rising edge acts
//   level_sel                   requested difficulty
//   score                       current score from the score counter
//   state                       IDLE=0 COUNTDOWN=1 PLAYING=2 PAUSED=3 GAME_OVER=4
//   enable_mole_ctrl,
//   enable_score                high only while PLAYING
//   clear_score                 one-clk pulse clearing the score counter
//   difficulty_level            latched, clamped difficulty
//   time_left                   remaining play seconds
//   display_value/display_mode  7-seg value and what it represents
//   high_score, new_high_score  best score and "last game set a record"
//   game_over_pulse             one-clk pulse on entry to GAME_OVER
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for start, shows high score
// COUNTDOWN | pre-game countdown, shows seconds to go
// PLAYING   | game running, time_left counting down
// PAUSED    | game frozen, shows remaining time
// GAME_OVER | game finished, shows final score
module game_session_ctrl #(
  parameter int COUNTDOWN_SEC = 5,
  parameter int GAME_SEC      = 30,
  parameter int TIME_W        = 6,
  parameter int SCORE_W       = 8,
  parameter int NUM_LEVELS    = 3,
  parameter int LVL_W         = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               btn_reset_score,
  input  logic [LVL_W-1:0]   level_sel,
  input  logic [SCORE_W-1:0] score,
  output logic [2:0]         state,
  output logic               enable_mole_ctrl,
  output logic               enable_score,
  output logic               clear_score,
  output logic [LVL_W-1:0]   difficulty_level,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] display_value,
  output logic [1:0]         display_mode,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high_score,
  output logic               game_over_pulse
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COUNTDOWN = 3'd1;
  localparam logic [2:0] S_PLAYING   = 3'd2;
  localparam logic [2:0] S_PAUSED    = 3'd3;
  localparam logic [2:0] S_GAME_OVER = 3'd4;

  localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [TIME_W-1:0] CD_LOAD  = TIME_W'(COUNTDOWN_SEC);
  localparam logic [TIME_W-1:0] GAME_LOAD = TIME_W'(GAME_SEC);

  logic [2:0]         state_q, state_d;
  logic [TIME_W-1:0]  cd_q, cd_d;
  logic [TIME_W-1:0]  tl_q, tl_d;
  logic [SCORE_W-1:0] hs_q, hs_d;
  logic               nhs_q, nhs_d;
  logic               clr_q, clr_d;
  logic               go_q, go_d;
  logic [LVL_W-1:0]   diff_q, diff_d;
  logic               start_q, pause_q, rs_q;

  logic start_rise, pause_rise, rs_rise;
  logic ev_start, ev_rs, ev_pause, ev_tick;
  logic do_load;
  logic [LVL_W-1:0] lvl_clamped;

  assign start_rise = btn_start & ~start_q;
  assign pause_rise = btn_pause & ~pause_q;
  assign rs_rise    = btn_reset_score & ~rs_q;

  // One event per cycle; lower-priority events in the same cycle are dropped.
  assign ev_start = start_rise;
  assign ev_rs    = rs_rise & ~start_rise;
  assign ev_pause = pause_rise & ~start_rise & ~rs_rise;
  assign ev_tick  = tick_1hz & ~start_rise & ~rs_rise & ~pause_rise;

  assign lvl_clamped = (level_sel > LVL_MAX) ? LVL_MAX : level_sel;

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    tl_d    = tl_q;
    hs_d    = hs_q;
    nhs_d   = nhs_q;
    clr_d   = 1'b0;
    go_d    = 1'b0;
    diff_d  = diff_q;
    do_load = 1'b0;

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        diff_d = lvl_clamped;
        if (ev_start) begin
          do_load = 1'b1;
        end else if (ev_rs) begin
          hs_d  = '0;
          nhs_d = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        if (ev_start) begin
          do_load = 1'b1;
        end else if (ev_tick && cd_q != '0) begin
          cd_d = cd_q - 1'b1;
          if (cd_q == TIME_W'(1)) state_d = S_PLAYING;
        end
      end
      S_PLAYING: begin
        if (ev_start) begin
          do_load = 1'b1;
        end else if (ev_rs) begin
          clr_d = 1'b1;
          tl_d  = GAME_LOAD;
        end else if (ev_pause) begin
          state_d = S_PAUSED;
        end else if (ev_tick && tl_q != '0) begin
          tl_d = tl_q - 1'b1;
          if (tl_q == TIME_W'(1)) begin
            state_d = S_GAME_OVER;
            go_d    = 1'b1;
            if (score > hs_q) begin
              hs_d  = score;
              nhs_d = 1'b1;
            end
          end
        end
      end
      S_PAUSED: begin
        if (ev_start) begin
          do_load = 1'b1;
        end else if (ev_rs) begin
          clr_d = 1'b1;
          tl_d  = GAME_LOAD;
        end else if (ev_pause) begin
          state_d = S_PLAYING;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_load) begin
      state_d = S_COUNTDOWN;
      cd_d    = CD_LOAD;
      tl_d    = GAME_LOAD;
      clr_d   = 1'b1;
      nhs_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cd_q    <= '0;
      tl_q    <= '0;
      hs_q    <= '0;
      nhs_q   <= 1'b0;
      clr_q   <= 1'b0;
      go_q    <= 1'b0;
      diff_q  <= '0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      tl_q    <= tl_d;
      hs_q    <= hs_d;
      nhs_q   <= nhs_d;
      clr_q   <= clr_d;
      go_q    <= go_d;
      diff_q  <= diff_d;
      start_q <= btn_start;
      pause_q <= btn_pause;
      rs_q    <= btn_reset_score;
    end
  end

  assign state            = state_q;
  assign enable_mole_ctrl = (state_q == S_PLAYING);
  assign enable_score     = (state_q == S_PLAYING);
  assign clear_score      = clr_q;
  assign difficulty_level = diff_q;
  assign time_left        = tl_q;
  assign high_score       = hs_q;
  assign new_high_score   = nhs_q;
  assign game_over_pulse  = go_q;

  always_comb begin
    display_value = hs_q;
    display_mode  = 2'd2;
    case (state_q)
      S_COUNTDOWN: begin
        display_value = SCORE_W'(cd_q);
        display_mode  = 2'd0;
      end
      S_PLAYING, S_GAME_OVER: begin
        display_value = score;
        display_mode  = 2'd1;
      end
      S_PAUSED: begin
        display_value = SCORE_W'(tl_q);
        display_mode  = 2'd3;
      end
      default: begin
        display_value = hs_q;
        display_mode  = 2'd2;
      end
    endcase
  end

endmodule

// File: tb/tb_game_session_ctrl.sv
module tb_game_session_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_reset_score = 1'b0;
  logic [1:0] level_sel = 2'd0;
  logic [7:0] score = 8'd0;
  logic [2:0] state;
  logic       enable_mole_ctrl, enable_score, clear_score;
  logic [1:0] difficulty_level;
  logic [5:0] time_left;
  logic [7:0] display_value;
  logic [1:0] display_mode;
  logic [7:0] high_score;
  logic       new_high_score, game_over_pulse;

  int passed = 0;
  int total  = 0;

  game_session_ctrl #(
    .COUNTDOWN_SEC(3), .GAME_SEC(5), .TIME_W(6), .SCORE_W(8), .NUM_LEVELS(3), .LVL_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_start(btn_start),
    .btn_pause(btn_pause), .btn_reset_score(btn_reset_score), .level_sel(level_sel),
    .score(score), .state(state), .enable_mole_ctrl(enable_mole_ctrl),
    .enable_score(enable_score), .clear_score(clear_score),
    .difficulty_level(difficulty_level), .time_left(time_left),
    .display_value(display_value), .display_mode(display_mode),
    .high_score(high_score), .new_high_score(new_high_score),
    .game_over_pulse(game_over_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({state, time_left, high_score, difficulty_level, new_high_score, clear_score, game_over_pulse}
        !== {3'd0, 6'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_regs: state=%0d tl=%0d hs=%0d diff=%0d nhs=%b clr=%b go=%b",
               state, time_left, high_score, difficulty_level, new_high_score, clear_score, game_over_pulse);
    else passed++;
    total++;
    if ({display_value, display_mode, enable_mole_ctrl, enable_score} !== {8'd0, 2'd2, 1'b0, 1'b0})
      $display("FAIL reset_disp: val=%0d mode=%0d en=%b%b expected 0 2 00",
               display_value, display_mode, enable_mole_ctrl, enable_score);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    level_sel = 2'd1;
    step();
  endtask

  task automatic test_countdown();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    total++;
    if ({state, clear_score, display_value, display_mode, time_left, difficulty_level}
        !== {3'd1, 1'b1, 8'd3, 2'd0, 6'd5, 2'd1})
      $display("FAIL cd_start: state=%0d clr=%b val=%0d mode=%0d tl=%0d diff=%0d exp 1 1 3 0 5 1",
               state, clear_score, display_value, display_mode, time_left, difficulty_level);
    else passed++;
    step();
    total++;
    if (clear_score !== 1'b0) $display("FAIL clr_one_cycle: got %b exp 0", clear_score);
    else passed++;
    tick();
    total++;
    if (display_value !== 8'd2) $display("FAIL cd_tick1: got %0d exp 2", display_value);
    else passed++;
    tick();
    total++;
    if (display_value !== 8'd1) $display("FAIL cd_tick2: got %0d exp 1", display_value);
    else passed++;
    score = 8'd12;
    tick();
    total++;
    if ({state, enable_mole_ctrl, enable_score, display_mode, display_value}
        !== {3'd2, 1'b1, 1'b1, 2'd1, 8'd12})
      $display("FAIL cd_to_play: state=%0d en=%b%b mode=%0d val=%0d exp 2 11 1 12",
               state, enable_mole_ctrl, enable_score, display_mode, display_value);
    else passed++;
  endtask

  task automatic test_play_game_over();
    level_sel = 2'd2;
    for (int i = 4; i >= 1; i--) begin
      tick();
      total++;
      if ({state, time_left} !== {3'd2, 6'(i)})
        $display("FAIL play_tick: state=%0d tl=%0d exp 2 %0d", state, time_left, i);
      else passed++;
    end
    total++;
    if (difficulty_level !== 2'd1) $display("FAIL diff_frozen: got %0d exp 1", difficulty_level);
    else passed++;
    tick();
    total++;
    if ({state, time_left, game_over_pulse, high_score, new_high_score, enable_mole_ctrl}
        !== {3'd4, 6'd0, 1'b1, 8'd12, 1'b1, 1'b0})
      $display("FAIL game_over: state=%0d tl=%0d go=%b hs=%0d nhs=%b en=%b exp 4 0 1 12 1 0",
               state, time_left, game_over_pulse, high_score, new_high_score, enable_mole_ctrl);
    else passed++;
    step();
    total++;
    if ({game_over_pulse, display_value, display_mode} !== {1'b0, 8'd12, 2'd1})
      $display("FAIL go_pulse_end: go=%b val=%0d mode=%0d exp 0 12 1",
               game_over_pulse, display_value, display_mode);
    else passed++;
  endtask

  task automatic test_levels();
    logic [1:0] exp_lvl [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    for (int i = 0; i < 4; i++) begin
      level_sel = 2'(i);
      step();
      total++;
      if (difficulty_level !== exp_lvl[i])
        $display("FAIL level_clamp: sel=%0d got %0d exp %0d", i, difficulty_level, exp_lvl[i]);
      else passed++;
    end
  endtask

  task automatic test_replay_tie();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    total++;
    if ({state, new_high_score, high_score} !== {3'd1, 1'b0, 8'd12})
      $display("FAIL replay_start: state=%0d nhs=%b hs=%0d exp 1 0 12", state, new_high_score, high_score);
    else passed++;
    repeat (3) tick();
    repeat (5) tick();
    total++;
    if ({state, high_score, new_high_score, game_over_pulse} !== {3'd4, 8'd12, 1'b0, 1'b1})
      $display("FAIL tie_no_update: state=%0d hs=%0d nhs=%b go=%b exp 4 12 0 1",
               state, high_score, new_high_score, game_over_pulse);
    else passed++;
  endtask

  task automatic test_pause();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    repeat (3) tick();
    repeat (2) tick();
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
    total++;
    if ({state, display_mode, display_value, enable_mole_ctrl} !== {3'd3, 2'd3, 8'd3, 1'b0})
      $display("FAIL pause_enter: state=%0d mode=%0d val=%0d en=%b exp 3 3 3 0",
               state, display_mode, display_value, enable_mole_ctrl);
    else passed++;
    repeat (4) tick();
    total++;
    if ({state, time_left} !== {3'd3, 6'd3})
      $display("FAIL pause_frozen: state=%0d tl=%0d exp 3 3", state, time_left);
    else passed++;
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
    total++;
    if (state !== 3'd2) $display("FAIL resume: state=%0d exp 2", state);
    else passed++;
    tick();
    total++;
    if (time_left !== 6'd2) $display("FAIL resume_tick: tl=%0d exp 2", time_left);
    else passed++;
  endtask

  task automatic test_reset_score_play();
    btn_reset_score = 1'b1;
    step();
    btn_reset_score = 1'b0;
    total++;
    if ({state, clear_score, time_left, high_score} !== {3'd2, 1'b1, 6'd5, 8'd12})
      $display("FAIL rs_play: state=%0d clr=%b tl=%0d hs=%0d exp 2 1 5 12",
               state, clear_score, time_left, high_score);
    else passed++;
    step();
    total++;
    if (clear_score !== 1'b0) $display("FAIL rs_clr_end: got %b exp 0", clear_score);
    else passed++;
  endtask

  task automatic test_back_to_back();
    tick();
    btn_start = 1'b1;
    btn_pause = 1'b1;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    btn_pause = 1'b0;
    total++;
    if ({state, display_value, time_left, clear_score} !== {3'd1, 8'd3, 6'd5, 1'b1})
      $display("FAIL b2b_restart: state=%0d cd=%0d tl=%0d clr=%b exp 1 3 5 1",
               state, display_value, time_left, clear_score);
    else passed++;
    for (int i = 0; i < 9; i++) begin
      tick_1hz = (i == 3 || i == 6);
      step();
      total++;
      if (clear_score !== 1'b0) $display("FAIL held_start_clr: cycle=%0d clr=%b exp 0", i, clear_score);
      else passed++;
    end
    tick_1hz = 1'b0;
    btn_start = 1'b0;
    total++;
    if ({state, display_value} !== {3'd1, 8'd1})
      $display("FAIL held_start_once: state=%0d cd=%0d exp 1 1", state, display_value);
    else passed++;
  endtask

  task automatic test_hs_clear();
    score = 8'd20;
    tick();
    repeat (5) tick();
    total++;
    if ({state, high_score, new_high_score} !== {3'd4, 8'd20, 1'b1})
      $display("FAIL new_record: state=%0d hs=%0d nhs=%b exp 4 20 1", state, high_score, new_high_score);
    else passed++;
    btn_reset_score = 1'b1;
    step();
    btn_reset_score = 1'b0;
    total++;
    if ({state, high_score, new_high_score} !== {3'd4, 8'd0, 1'b0})
      $display("FAIL hs_clear: state=%0d hs=%0d nhs=%b exp 4 0 0", state, high_score, new_high_score);
    else passed++;
  endtask

  task automatic test_async_reset();
    score = 8'd9;
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    repeat (3) tick();
    repeat (5) tick();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    repeat (3) tick();
    tick();
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
    total++;
    if ({state, time_left, high_score} !== {3'd3, 6'd4, 8'd9})
      $display("FAIL pre_reset: state=%0d tl=%0d hs=%0d exp 3 4 9", state, time_left, high_score);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({state, time_left, high_score, difficulty_level, display_mode, display_value}
        !== {3'd0, 6'd0, 8'd0, 2'd0, 2'd2, 8'd0})
      $display("FAIL async_reset: state=%0d tl=%0d hs=%0d diff=%0d mode=%0d val=%0d exp 0 0 0 0 2 0",
               state, time_left, high_score, difficulty_level, display_mode, display_value);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_play_game_over();
    test_levels();
    test_replay_tie();
    test_pause();
    test_reset_score_play();
    test_back_to_back();
    test_hs_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
